// File: rtl/dmem_pkg.sv
// Shared types, func3 encodings and request-validity check for the data memory controller.
package dmem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StMerge,
        StWrite,
        StResp
    } t_dmem_state;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // High when the request must be answered with an error instead of touching the SRAM.
    function automatic logic req_bad(input logic write_en, input logic [2:0] func3,
                                     input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (write_en) begin
            illegal = !(func3 == F3_B || func3 == F3_H || func3 == F3_W);
        end else begin
            illegal = !(func3 == F3_B || func3 == F3_H || func3 == F3_W ||
                        func3 == F3_BU || func3 == F3_HU);
        end
        misaligned = (func3[1:0] == 2'b01 && off[0]) ||
                     (func3[1:0] == 2'b10 && off != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Selects the byte/half lane of a word and sign- or zero-extends it according to func3.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (func3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder for the RV32I core: one request at a time onto a single-port word SRAM,
// with read-modify-write for sub-word stores.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_addr,
    input  logic              i_write_en,
    input  logic [2:0]        i_func_3,
    input  logic [31:0]       i_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    t_dmem_state       state_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;

    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [4:0]  lane_shift;
    logic [31:0] merged;
    logic        unused_addr;

    assign unused_addr = ^i_addr[31:ADDR_W+2];

    load_align u_load (
        .word_i  (i_ram_rdata),
        .off_i   (off_q),
        .func3_i (f3_q),
        .data_o  (load_val)
    );

    // Unsigned variant of the store size yields an all-ones lane mask (0xFF or 0xFFFF).
    load_align u_mask (
        .word_i  (32'hFFFF_FFFF),
        .off_i   (2'b00),
        .func3_i ({1'b1, f3_q[1:0]}),
        .data_o  (lane_mask)
    );

    always_comb begin
        lane_shift = {off_q, 3'b000};
        merged     = (i_ram_rdata & ~(lane_mask << lane_shift)) |
                     ((wdata_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q     <= StIdle;
            off_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        off_q      <= i_addr[1:0];
                        we_q       <= i_write_en;
                        f3_q       <= i_func_3;
                        wdata_q    <= i_wdata;
                        ram_addr_q <= i_addr[ADDR_W+1:2];
                        if (req_bad(i_write_en, i_func_3, i_addr[1:0])) begin
                            err_q       <= 1'b1;
                            rdata_q     <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else if (i_write_en && i_func_3 == F3_W) begin
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= i_wdata;
                            state_q     <= StWrite;
                        end else begin
                            ram_en_q <= 1'b1;
                            ram_we_q <= 1'b0;
                            state_q  <= StRead;
                        end
                    end
                end
                StRead: begin
                    ram_en_q <= 1'b0;
                    state_q  <= StMerge;
                end
                StMerge: begin
                    if (we_q) begin
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= merged;
                        state_q     <= StWrite;
                    end else begin
                        rdata_q     <= load_val;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StWrite: begin
                    ram_en_q    <= 1'b0;
                    ram_we_q    <= 1'b0;
                    rdata_q     <= '0;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_req_ready = (state_q == StIdle);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_ram_en    = ram_en_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference memory, per-cycle compare process, directed loads/stores.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_addr;
    logic        i_write_en;
    logic [2:0]  i_func_3;
    logic [31:0] i_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_ram_en;
    logic        o_ram_we;
    logic [9:0]  o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(10)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_addr      (i_addr),
        .i_write_en  (i_write_en),
        .i_func_3    (i_func_3),
        .i_wdata     (i_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_ram_en    (o_ram_en),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    // Synchronous single-port SRAM around the DUT.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) sram[o_ram_addr] <= o_ram_wdata;
            else          ram_rdata <= sram[o_ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus expected response for the current request.
    logic [7:0]  rmem [0:4095];
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    logic [9:0]  exp_waddr;
    int          exp_lat;
    logic        exp_sw;
    logic        exp_rmw;

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int          n;
        int          a;
        logic        legal;
        logic [31:0] v;
        a     = int'(addr[11:0]);
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_err   = !legal || (a % n != 0);
        exp_waddr = addr[11:2];
        exp_sw    = we && !exp_err && n == 4;
        exp_rmw   = we && !exp_err && n < 4;
        exp_rdata = 32'h0;
        exp_lat   = 1;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < n; b++) rmem[a + b] = wdata[8*b +: 8];
                exp_lat = (n == 4) ? 2 : 4;
            end else begin
                v = 32'h0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = rmem[a + b];
                if (!f3[2] && n < 4 && v[8*n-1]) begin
                    for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
                end
                exp_rdata = v;
                exp_lat   = 3;
            end
        end
        a = a & ~3;
        exp_wword = {rmem[a + 3], rmem[a + 2], rmem[a + 1], rmem[a]};
    endtask

    // Per-cycle compare of the DUT against the expected transaction schedule.
    logic        txn_active = 1'b0;
    int          cyc = 0;
    logic        en_exp;
    logic        we_exp;
    logic [31:0] last_wword = 32'h0;

    always @(negedge clk) begin
        if (!txn_active) begin
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            en_exp = !exp_err && (cyc == 1 || (exp_rmw && cyc == 3));
            we_exp = (exp_sw && cyc == 1) || (exp_rmw && cyc == 3);
            chk("ram_en", {31'h0, o_ram_en}, {31'h0, en_exp});
            chk("ram_we", {31'h0, o_ram_we}, {31'h0, we_exp});
            if (en_exp) chk("ram_addr", {22'h0, o_ram_addr}, {22'h0, exp_waddr});
            if (we_exp) begin
                chk("ram_wdata", o_ram_wdata, exp_wword);
                last_wword = o_ram_wdata;
            end
            chk("rsp_valid", {31'h0, o_rsp_valid}, {31'h0, cyc >= exp_lat});
            chk("req_ready_busy", {31'h0, o_req_ready}, 32'h0);
            if (o_rsp_valid) begin
                chk("rdata", o_rdata, exp_rdata);
                chk("err", {31'h0, o_err}, {31'h0, exp_err});
            end
        end
    end

    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        logic seen;
        model(we, f3, addr, wdata);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_write_en  = we;
        i_func_3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        txn_active  = 1'b1;
        seen        = 1'b0;
        got_lat     = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            got_lat++;
            if (o_rsp_valid) seen = 1'b1;
        end
        chk("rsp_seen", {31'h0, seen}, 32'h1);
        chk("latency", got_lat, exp_lat);
        got_rdata = o_rdata;
        got_err   = o_err;
        repeat (hold) @(negedge clk);
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
        txn_active  = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'h0, o_req_ready}, 32'h1);
        chk("idle_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        chk("idle_ram_en", {31'h0, o_ram_en}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {31'h0, o_rsp_valid}, 32'h0);
        chk({tag, "_err"}, {31'h0, o_err}, 32'h0);
        chk({tag, "_rdata"}, o_rdata, 32'h0);
        chk({tag, "_ram_en"}, {31'h0, o_ram_en}, 32'h0);
        chk({tag, "_ram_we"}, {31'h0, o_ram_we}, 32'h0);
        chk({tag, "_ram_addr"}, {22'h0, o_ram_addr}, 32'h0);
        chk({tag, "_ram_wdata"}, o_ram_wdata, 32'h0);
        chk({tag, "_req_ready"}, {31'h0, o_req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rmem[i] = 8'h0;
        arstn       = 1'b0;
        i_req_valid = 1'b0;
        i_addr      = 32'h0;
        i_write_en  = 1'b0;
        i_func_3    = 3'b000;
        i_wdata     = 32'h0;
        i_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        arstn = 1'b1;

        // Word load after preloading word 4.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("lw_lit", got_rdata, 32'hDEAD_BEEF);
        chk("lw_lat_lit", got_lat, 3);

        // Sub-word loads with sign and zero extension.
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
        chk("lb_lit", got_rdata, 32'hFFFF_FFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        chk("lbu_lit", got_rdata, 32'h0000_00DE);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1);
        chk("lh_lit", got_rdata, 32'hFFFF_DEAD);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 0);
        chk("lhu_lit", got_rdata, 32'h0000_DEAD);

        // Byte store read-modify-write.
        do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, 0);
        do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 0);
        chk("sb_merge_lit", last_wword, 32'h1122_AA44);
        chk("sb_lat_lit", got_lat, 4);
        chk("sb_rdata_lit", got_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("sb_readback_lit", got_rdata, 32'h1122_AA44);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 0);
        chk("lb_pos_lit", got_rdata, 32'h0000_0044);

        // Upper-half store.
        do_req(1'b1, 3'b010, 32'h14, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 0);
        chk("sh_merge_lit", last_wword, 32'hBEEF_0000);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 0);
        chk("sh_readback_lit", got_rdata, 32'hBEEF_0000);

        // Full-word store and a held response.
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 0);
        chk("sw_lat_lit", got_lat, 2);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5);
        chk("sw_readback_lit", got_rdata, 32'hCAFE_F00D);

        // Error cases: no SRAM access, single-cycle response.
        do_req(1'b0, 3'b001, 32'h01, 32'h0, 0);
        chk("lh_mis_err_lit", {31'h0, got_err}, 32'h1);
        chk("lh_mis_lat_lit", got_lat, 1);
        do_req(1'b1, 3'b011, 32'h10, 32'h55, 0);
        chk("sb_ill_err_lit", {31'h0, got_err}, 32'h1);
        chk("sb_ill_rdata_lit", got_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h22, 32'h0, 0);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'h77, 2);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("after_err_lit", got_rdata, 32'h1122_AA44);

        // Upper address bits are ignored.
        do_req(1'b0, 3'b010, 32'h1000_0010, 32'h0, 0);
        chk("wrap_lit", got_rdata, 32'h1122_AA44);

        // Reset while in READ abandons the load.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_write_en  = 1'b0;
        i_func_3    = 3'b010;
        i_addr      = 32'h10;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("midread_ram_en", {31'h0, o_ram_en}, 32'h1);
        arstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midread_reset");
        arstn = 1'b1;

        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0);
        chk("post_reset_lit", got_rdata, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
